// File: rtl/sw_pkg.sv
// Shared types and constants for the Smith-Waterman array controller slice.
package sw_pkg;

    typedef enum logic [1:0] {
        BASE_A = 2'b00,
        BASE_G = 2'b01,
        BASE_T = 2'b10,
        BASE_C = 2'b11
    } sw_base_t;

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        DRAIN,
        RESULT,
        FLUSH
    } sw_state_t;

    localparam int LUT_MATCH_RST      = 2;
    localparam int LUT_MISMATCH_RST   = -1;
    localparam int LUT_GAP_OPEN_RST   = -2;
    localparam int LUT_GAP_EXTEND_RST = -1;

    // Scores in the PE chain are offset so that local-alignment zero sits at mid-range.
    function automatic int unsigned bias(input int unsigned score_width);
        return 32'd1 << (score_width - 32'd1);
    endfunction

endpackage

// File: rtl/sw_cfg_regs.sv
// Scoring LUT and query shift register for the PE chain; writes land only while
// the controller is idle so both stay stable for a whole job.
module sw_cfg_regs
    import sw_pkg::*;
#(
    parameter int unsigned SCORE_WIDTH = 12,
    parameter int unsigned N_PE        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_en,
    input  logic                   cfg_wr,
    input  logic [1:0]             cfg_addr,
    input  logic [SCORE_WIDTH-1:0] cfg_data,
    input  logic                   q_wr,
    input  logic [1:0]             q_base,
    output logic [SCORE_WIDTH-1:0] match,
    output logic [SCORE_WIDTH-1:0] mismatch,
    output logic [SCORE_WIDTH-1:0] gap_open,
    output logic [SCORE_WIDTH-1:0] gap_extend,
    output logic [2*N_PE-1:0]      query
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match      <= SCORE_WIDTH'(LUT_MATCH_RST);
            mismatch   <= SCORE_WIDTH'(LUT_MISMATCH_RST);
            gap_open   <= SCORE_WIDTH'(LUT_GAP_OPEN_RST);
            gap_extend <= SCORE_WIDTH'(LUT_GAP_EXTEND_RST);
            query      <= '0;
        end else if (cfg_en) begin
            if (cfg_wr) begin
                case (cfg_addr)
                    2'd0:    match      <= cfg_data;
                    2'd1:    mismatch   <= cfg_data;
                    2'd2:    gap_open   <= cfg_data;
                    default: gap_extend <= cfg_data;
                endcase
            end
            // Newest base enters at PE0; older bases move toward the chain tail.
            if (q_wr) begin
                query <= {query[2*N_PE-3:0], q_base};
            end
        end
    end

endmodule

// File: rtl/sw_array_controller.sv
// Smith-Waterman array controller: configures a linear PE chain, streams one
// target burst through it and returns the unbiased best local score.
module sw_array_controller
    import sw_pkg::*;
#(
    parameter int unsigned SCORE_WIDTH = 12,
    parameter int unsigned N_PE        = 16,
    parameter int unsigned TLEN_W      = 16,
    parameter int unsigned DRAIN_MAX   = N_PE + 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_wr,
    input  logic [1:0]             cfg_addr,
    input  logic [SCORE_WIDTH-1:0] cfg_data,
    input  logic                   q_wr,
    input  logic [1:0]             q_base,
    input  logic                   start,
    input  logic [TLEN_W-1:0]      tgt_len,
    input  logic                   tgt_valid,
    input  logic [1:0]             tgt_base,
    output logic                   tgt_ready,
    input  logic                   abort,
    output logic                   arr_en,
    output logic [1:0]             arr_data,
    output logic [2*N_PE-1:0]      arr_query,
    output logic [SCORE_WIDTH-1:0] match,
    output logic [SCORE_WIDTH-1:0] mismatch,
    output logic [SCORE_WIDTH-1:0] gap_open,
    output logic [SCORE_WIDTH-1:0] gap_extend,
    input  logic [SCORE_WIDTH-1:0] arr_high,
    input  logic                   arr_vld,
    output logic                   res_valid,
    output logic [SCORE_WIDTH-1:0] res_score,
    output logic                   res_err,
    input  logic                   res_ready,
    output logic                   busy
);

    localparam int unsigned DCW = $clog2(DRAIN_MAX + 1);
    localparam int unsigned FCW = $clog2(N_PE + 2);
    localparam logic [SCORE_WIDTH-1:0] BIAS_V = SCORE_WIDTH'(bias(SCORE_WIDTH));

    sw_state_t         state;
    logic [TLEN_W-1:0] len;
    logic [TLEN_W-1:0] cnt;
    logic [DCW-1:0]    drain_cnt;
    logic [FCW-1:0]    flush_cnt;
    logic              err;

    assign busy = (state != IDLE);

    sw_cfg_regs #(
        .SCORE_WIDTH (SCORE_WIDTH),
        .N_PE        (N_PE)
    ) u_cfg_regs (
        .clk        (clk),
        .rst        (rst),
        .cfg_en     (state == IDLE),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .q_wr       (q_wr),
        .q_base     (q_base),
        .match      (match),
        .mismatch   (mismatch),
        .gap_open   (gap_open),
        .gap_extend (gap_extend),
        .query      (arr_query)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            arr_en    <= 1'b0;
            arr_data  <= '0;
            tgt_ready <= 1'b0;
            res_valid <= 1'b0;
            res_score <= '0;
            res_err   <= 1'b0;
            len       <= '0;
            cnt       <= '0;
            drain_cnt <= '0;
            flush_cnt <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        cnt <= '0;
                        len <= tgt_len;
                        if (tgt_len == '0) begin
                            state     <= RESULT;
                            res_valid <= 1'b1;
                            res_score <= '0;
                            res_err   <= 1'b0;
                        end else begin
                            state     <= STREAM;
                            tgt_ready <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (abort) begin
                        arr_en    <= 1'b0;
                        tgt_ready <= 1'b0;
                        flush_cnt <= '0;
                        state     <= FLUSH;
                    end else if (tgt_valid) begin
                        arr_en   <= 1'b1;
                        arr_data <= tgt_base;
                        cnt      <= cnt + TLEN_W'(1);
                        if (cnt + TLEN_W'(1) == len) begin
                            tgt_ready <= 1'b0;
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end
                    end else begin
                        // A hole in the burst corrupts the chain; finish the job flagged.
                        err       <= 1'b1;
                        arr_en    <= 1'b0;
                        tgt_ready <= 1'b0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    arr_en <= 1'b0;
                    if (abort) begin
                        flush_cnt <= '0;
                        state     <= FLUSH;
                    end else if (arr_vld) begin
                        state     <= RESULT;
                        res_valid <= 1'b1;
                        if (!arr_high[SCORE_WIDTH-1]) begin
                            res_score <= '0;
                            res_err   <= 1'b1;
                        end else begin
                            res_score <= arr_high - BIAS_V;
                            res_err   <= err;
                        end
                    end else if (!arr_en) begin
                        // Timeout is measured from the cycle arr_en is seen low.
                        if (drain_cnt == DCW'(DRAIN_MAX - 1)) begin
                            state     <= RESULT;
                            res_valid <= 1'b1;
                            res_score <= '0;
                            res_err   <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + DCW'(1);
                        end
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FCW'(N_PE + 1)) begin
                        state <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt + FCW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sw_array_controller.sv
// Self-checking bench for sw_array_controller with a behavioural PE-chain responder
// and an affine-gap Smith-Waterman reference for the expected scores.
module tb_sw_array_controller;
    import sw_pkg::*;

    localparam int unsigned SW   = 12;
    localparam int unsigned NPE  = 4;
    localparam int unsigned TLW  = 16;
    localparam int unsigned DMAX = NPE + 4;
    localparam int BIAS_I = int'(bias(SW));
    localparam logic [SW-1:0] L_M1 = SW'(-1);
    localparam logic [SW-1:0] L_M2 = SW'(-2);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cfg_wr = 1'b0;
    logic [1:0]        cfg_addr = '0;
    logic [SW-1:0]     cfg_data = '0;
    logic              q_wr = 1'b0;
    logic [1:0]        q_base = '0;
    logic              start = 1'b0;
    logic [TLW-1:0]    tgt_len = '0;
    logic              tgt_valid = 1'b0;
    logic [1:0]        tgt_base = '0;
    logic              tgt_ready;
    logic              abort = 1'b0;
    logic              arr_en;
    logic [1:0]        arr_data;
    logic [2*NPE-1:0]  arr_query;
    logic [SW-1:0]     match, mismatch, gap_open, gap_extend;
    logic [SW-1:0]     arr_high = '0;
    logic              arr_vld = 1'b0;
    logic              res_valid;
    logic [SW-1:0]     res_score;
    logic              res_err;
    logic              res_ready = 1'b0;
    logic              busy;

    sw_array_controller #(
        .SCORE_WIDTH (SW),
        .N_PE        (NPE),
        .TLEN_W      (TLW),
        .DRAIN_MAX   (DMAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .q_wr       (q_wr),
        .q_base     (q_base),
        .start      (start),
        .tgt_len    (tgt_len),
        .tgt_valid  (tgt_valid),
        .tgt_base   (tgt_base),
        .tgt_ready  (tgt_ready),
        .abort      (abort),
        .arr_en     (arr_en),
        .arr_data   (arr_data),
        .arr_query  (arr_query),
        .match      (match),
        .mismatch   (mismatch),
        .gap_open   (gap_open),
        .gap_extend (gap_extend),
        .arr_high   (arr_high),
        .arr_vld    (arr_vld),
        .res_valid  (res_valid),
        .res_score  (res_score),
        .res_err    (res_err),
        .res_ready  (res_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    int          m_match = 2, m_mis = -1, m_go = -2, m_ge = -1;
    logic [1:0]  qv[$];
    logic [1:0]  tgt_q[$];
    logic [SW:0] sb[$];

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int sw_score(input int tl);
        int prev_h[$], prev_f[$], cur_h[$], cur_f[$];
        int e, f, h, s, best;
        best = 0;
        for (int j = 0; j <= tl; j++) begin
            prev_h.push_back(0);
            prev_f.push_back(-1000);
        end
        for (int i = 0; i < int'(NPE); i++) begin
            cur_h.delete(); cur_f.delete();
            cur_h.push_back(0); cur_f.push_back(-1000);
            e = -1000;
            for (int j = 1; j <= tl; j++) begin
                s = (qv[i] == tgt_q[j-1]) ? m_match : m_mis;
                e = imax(cur_h[j-1] + m_go + m_ge, e + m_ge);
                f = imax(prev_h[j] + m_go + m_ge, prev_f[j] + m_ge);
                h = imax(0, imax(prev_h[j-1] + s, imax(e, f)));
                cur_h.push_back(h);
                cur_f.push_back(f);
                best = imax(best, h);
            end
            prev_h = cur_h;
            prev_f = cur_f;
        end
        return best;
    endfunction

    task automatic load_targets(input int n, input logic [31:0] packed_t);
        tgt_q.delete();
        for (int i = 0; i < n; i++) tgt_q.push_back(packed_t[2*i +: 2]);
    endtask

    // Output monitor: burst capture, timing marks and scoreboard pop on handshake
    int         cyc = 0;
    int         en_cycles = 0, bursts = 0, rv_rises = 0;
    int         fall_cyc = 0, rv_cyc = 0;
    bit         prev_en = 1'b0, prev_rv = 1'b0;
    logic [1:0] burst_q[$];
    logic [SW:0] sb_e;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (arr_en) begin
                en_cycles++;
                burst_q.push_back(arr_data);
                if (!prev_en) bursts++;
            end
            if (prev_en && !arr_en) fall_cyc = cyc;
            if (res_valid && !prev_rv) begin
                rv_cyc = cyc;
                rv_rises++;
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    check("res_expected", 32'(sb.size()), 1);
                end else begin
                    sb_e = sb.pop_front();
                    check("res_score", 32'(res_score), 32'(sb_e[SW-1:0]));
                    check("res_err", 32'(res_err), 32'(sb_e[SW]));
                end
            end
            prev_en = arr_en;
            prev_rv = res_valid;
        end
    end

    task automatic run_job(input int tl, input int gap_at, input bit give_vld, input int vld_lat,
                           input logic [SW-1:0] high_val, input logic [SW-1:0] exp_score,
                           input bit exp_err, input int stall, input bit poke_cfg,
                           input bit check_to);
        int idx, budget, en0, b0, exp_acc;
        bit gapped;
        exp_acc = (gap_at >= 0 && gap_at < tl) ? gap_at : tl;
        en0 = en_cycles;
        b0  = bursts;
        burst_q.delete();
        tgt_len = TLW'(tl);
        start = 1'b1;
        tick();
        start  = 1'b0;
        cfg_wr = 1'b0;
        sb.push_back({exp_err, exp_score});
        if (tl == 0) check("len0_rv", 32'(res_valid), 1);
        idx = 0; budget = 0; gapped = 1'b0;
        while (tgt_ready && budget < 64) begin
            if (idx == gap_at && !gapped) begin
                tgt_valid = 1'b0;
                gapped = 1'b1;
            end else begin
                tgt_valid = 1'b1;
                tgt_base  = tgt_q[idx];
            end
            tick();
            if (tgt_valid) idx++;
            budget++;
        end
        tgt_valid = 1'b0;
        check("accepted", idx, exp_acc);
        budget = 0;
        while (arr_en && budget < 4) begin
            tick();
            budget++;
        end
        check("en_fell", 32'(arr_en), 0);
        if (give_vld) begin
            repeat (vld_lat) tick();
            arr_high = high_val;
            arr_vld  = 1'b1;
            tick();
            arr_vld  = 1'b0;
        end
        budget = 0;
        while (!res_valid && budget < int'(2*DMAX + 8)) begin
            tick();
            budget++;
        end
        check("res_valid_seen", 32'(res_valid), 1);
        for (int k = 0; k < stall; k++) begin
            cfg_wr   = poke_cfg && (k == 0);
            cfg_addr = 2'd0;
            cfg_data = SW'(9);
            check("hold_score", 32'(res_score), 32'(exp_score));
            check("hold_valid", 32'(res_valid), 1);
            tick();
        end
        cfg_wr    = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("res_valid_clr", 32'(res_valid), 0);
        check("busy_idle", 32'(busy), 0);
        check("burst_cnt", bursts - b0, (exp_acc > 0) ? 1 : 0);
        check("burst_len", en_cycles - en0, exp_acc);
        for (int i = 0; i < burst_q.size(); i++)
            check("burst_data", 32'(burst_q[i]), 32'(tgt_q[i]));
        if (check_to) check("drain_timeout", rv_cyc - fall_cyc, DMAX);
    endtask

    logic [SW-1:0] hv;
    int sc, n, rv0, en0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_match", 32'(match), 2);
        check("rst_mismatch", 32'(mismatch), 32'(L_M1));
        check("rst_gap_open", 32'(gap_open), 32'(L_M2));
        check("rst_gap_ext", 32'(gap_extend), 32'(L_M1));
        check("rst_arr_en", 32'(arr_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_tgt_ready", 32'(tgt_ready), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_query", 32'(arr_query), 0);
        check("rst_res_score", 32'(res_score), 0);
        rst = 1'b1;
        tick();

        // Query A,C,G,T at PE0..PE3: shift in oldest (PE3) first
        qv.delete();
        qv.push_back(BASE_A); qv.push_back(BASE_C); qv.push_back(BASE_G); qv.push_back(BASE_T);
        for (int i = int'(NPE) - 1; i >= 0; i--) begin
            q_wr = 1'b1;
            q_base = qv[i];
            tick();
        end
        q_wr = 1'b0;
        check("query_load", 32'(arr_query), 32'h9C);

        // Identical target: four matches
        load_targets(4, 32'h0000_009C);
        sc = sw_score(4);
        hv = SW'(BIAS_I + sc);
        run_job(4, -1, 1'b1, 3, hv, SW'(8), 1'b0, 0, 1'b0, 1'b0);

        // Zero-length job
        run_job(0, -1, 1'b0, 0, '0, '0, 1'b0, 0, 1'b0, 1'b0);

        // Stream hole after base 3 of 10
        load_targets(10, 32'h000D_B29C);
        sc = sw_score(3);
        hv = SW'(BIAS_I + sc);
        run_job(10, 3, 1'b1, 2, hv, SW'(sc), 1'b1, 0, 1'b0, 1'b0);

        // No vld from the chain: drain timeout
        load_targets(4, 32'h0000_0036);
        run_job(4, -1, 1'b0, 0, '0, '0, 1'b1, 0, 1'b0, 1'b1);

        // Abort mid-stream
        load_targets(8, 32'h0000_A5C3);
        tgt_len = TLW'(8);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tgt_valid = 1'b1;
            tgt_base = tgt_q[k];
            tick();
        end
        abort = 1'b1;
        tgt_base = tgt_q[3];
        tick();
        abort = 1'b0;
        tgt_valid = 1'b0;
        check("abort_en", 32'(arr_en), 0);
        check("abort_rdy", 32'(tgt_ready), 0);
        check("abort_busy", 32'(busy), 1);
        rv0 = rv_rises;
        en0 = en_cycles;
        n = 1;
        while (busy && n < 64) begin
            tick();
            if (busy) n++;
        end
        check("flush_len", n, NPE + 2);
        repeat (2) tick();
        check("flush_no_res", rv_rises - rv0, 0);
        check("flush_no_en", en_cycles - en0, 0);

        // New job after abort; match rewritten with start, held result, write in RESULT ignored
        m_match = 3;
        load_targets(6, 32'h0000_0B72);
        sc = sw_score(6);
        hv = SW'(BIAS_I + sc);
        cfg_wr = 1'b1;
        cfg_addr = 2'd0;
        cfg_data = SW'(3);
        run_job(6, -1, 1'b1, 4, hv, SW'(sc), 1'b0, 5, 1'b1, 1'b0);
        check("cfg_with_start", 32'(match), 3);

        // Chain reports a below-bias value
        load_targets(2, 32'h0000_0003);
        run_job(2, -1, 1'b1, 1, SW'(12'h7F0), '0, 1'b1, 0, 1'b0, 1'b0);

        // Asynchronous reset mid-stream
        load_targets(6, 32'h0000_0E4B);
        tgt_len = TLW'(6);
        start = 1'b1;
        tick();
        start = 1'b0;
        tgt_valid = 1'b1;
        tgt_base = tgt_q[0];
        tick();
        tgt_base = tgt_q[1];
        tick();
        check("mid_busy", 32'(busy), 1);
        check("mid_en", 32'(arr_en), 1);
        #2 rst = 1'b0;
        #1;
        check("arst_en", 32'(arr_en), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_rdy", 32'(tgt_ready), 0);
        check("arst_match", 32'(match), 2);
        check("arst_query", 32'(arr_query), 0);
        check("arst_data", 32'(arr_data), 0);
        tgt_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("post_rst_busy", 32'(busy), 0);

        check("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
